mem_port_arbiter: RTL

Arbitrates a single shared memory backend between the fetch stage (10-byte instruction window) and the memory stage (64-bit data load/store) of the pipelined Y86-64 core. Sits between the fetch/memory stages and one unified single-port memory. Grants one transaction at a time, tracks the outstanding access, returns data and an error flag to the winner, and stalls the loser. Also provides a timeout watchdog and anti-starvation for fetch.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_grant.sv | 28 ++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and owner encodings plus default bus widths.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_LINE_W = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arbState_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select: data port first, fetch when starved.
// Purely combinational; sampled by the FSM only in IDLE.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             ifReq,
    input  logic             dmReq,
    input  logic [CNT_W-1:0] starveCnt,
    output owner_e           winner,
    output logic             anyReq
);

    logic starved;

    assign starved = (starveCnt == CNT_W'(STARVE_MAX));
    assign anyReq  = ifReq | dmReq;

    always_comb begin
        winner = OWN_DM;
        if (ifReq && (!dmReq || starved)) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backend port between fetch and memory stage.
// One outstanding access; IDLE -> WAIT -> RESP per transaction.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [LINE_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_err,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    input  logic              mem_err
);

    localparam int WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    arbState_e           state;
    arbState_e           nextState;
    owner_e              owner;
    owner_e              winner;
    logic                anyReq;
    logic                ownerWe;
    logic [WAIT_W-1:0]   waitCnt;
    logic [STARVE_W-1:0] starveCnt;
    logic [LINE_W-1:0]   ifLine;
    logic [DATA_W-1:0]   dmData;
    logic                respErr;
    logic                grantNow;
    logic                rspHit;
    logic                rspTimeout;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (STARVE_W)
    ) uGrant (
        .ifReq     (if_req),
        .dmReq     (dm_req),
        .starveCnt (starveCnt),
        .winner    (winner),
        .anyReq    (anyReq)
    );

    assign grantNow   = (state == IDLE) && anyReq;
    assign rspHit     = (state == WAIT) && mem_rvalid;
    assign rspTimeout = (state == WAIT) && !mem_rvalid
                        && (waitCnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (anyReq) nextState = WAIT;
            WAIT: if (rspHit || rspTimeout) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Backend request is driven straight from the winner in IDLE.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_valid  = 1'b0;
        dm_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (anyReq && !rst) begin
                    mem_req = 1'b1;
                    if (winner == OWN_DM) begin
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                    end else begin
                        mem_addr = if_addr;
                    end
                end
            end
            WAIT: ;
            RESP: begin
                if_valid = (owner == OWN_IF);
                dm_valid = (owner == OWN_DM);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner   <= OWN_DM;
            ownerWe <= 1'b0;
            waitCnt <= '0;
        end else if (grantNow) begin
            owner   <= winner;
            ownerWe <= (winner == OWN_DM) && dm_we;
            waitCnt <= '0;
        end else if (state == WAIT) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    // Counts data grants that left a waiting fetch behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (grantNow) begin
            if (winner == OWN_IF) begin
                starveCnt <= '0;
            end else if (if_req && (starveCnt != STARVE_W'(STARVE_MAX))) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifLine  <= '0;
            dmData  <= '0;
            respErr <= 1'b0;
        end else if (rspHit || rspTimeout) begin
            respErr <= rspHit ? mem_err : 1'b1;
            if (owner == OWN_IF) begin
                ifLine <= rspHit ? mem_rdata : '0;
            end else if (!ownerWe) begin
                dmData <= rspHit ? mem_rdata[LINE_W-1 -: DATA_W] : '0;
            end
        end
    end

    assign if_rdata = ifLine;
    assign dm_rdata = dmData;
    assign if_err   = if_valid & respErr;
    assign dm_err   = dm_valid & respErr;
    assign if_stall = if_req & !if_valid & !rst;
    assign dm_stall = dm_req & !dm_valid & !rst;

endmodule
